// File: rtl/mux5_arb_pkg.sv
// Shared types and constants for the five-way round-robin mux arbiter.
package mux5_arb_pkg;

    localparam int unsigned N_REQ = 5;
    localparam int unsigned IDX_W = 3;

    localparam logic [IDX_W-1:0] SEL_IDLE = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Next requester index in the circular order 0..4.
    function automatic logic [IDX_W-1:0] inc_mod5(input logic [IDX_W-1:0] i);
        return (i >= 3'd4) ? 3'd0 : i + 3'd1;
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping 4 -> 0.
module rr_pick5
    import mux5_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = IDX_W'((int'(ptr) + k) % int'(N_REQ));
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared mux5to1; grants are held until
// release or until the hold limit expires while others wait.
module mux5_rr_arbiter
    import mux5_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] sel,
    output logic             busy
);

    localparam int unsigned CNT_RAW = $clog2(MAX_HOLD + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam bit          HOLD_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] sel_q,   sel_d;
    logic             busy_q,  busy_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             owner_req;
    logic             others_req;
    logic             do_grant;
    logic             go_idle;

    rr_pick5 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= SEL_IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        do_grant   = 1'b0;
        go_idle    = 1'b0;
        owner_req  = |(req & grant_q);
        others_req = |(req & ~grant_q);

        case (state_q)
            IDLE: begin
                if (en && pick_found) begin
                    do_grant = 1'b1;
                end
            end
            GRANT: begin
                // Release takes precedence over an expiring hold on the same edge.
                if (!owner_req) begin
                    if (en && pick_found) begin
                        do_grant = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (HOLD_EN && (cnt_q == HOLD_LAST) && en && others_req) begin
                    do_grant = 1'b1;
                end else if (HOLD_EN && (cnt_q != HOLD_LAST)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (do_grant) begin
            state_d = GRANT;
            grant_d = N_REQ'(1) << pick_idx;
            sel_d   = pick_idx;
            busy_d  = 1'b1;
            ptr_d   = inc_mod5(pick_idx);
            cnt_d   = '0;
        end else if (go_idle) begin
            state_d = IDLE;
            grant_d = '0;
            sel_d   = SEL_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Directed bench for mux5_rr_arbiter: one instance with MAX_HOLD=4, one with unlimited hold.
module tb_mux5_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [4:0] req;

    logic [4:0] grant4, grant0;
    logic [2:0] sel4,   sel0;
    logic       busy4,  busy0;

    int n_vec;
    int n_err;

    mux5_rr_arbiter #(.MAX_HOLD(4)) u_arb4 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .grant (grant4),
        .sel   (sel4),
        .busy  (busy4)
    );

    mux5_rr_arbiter #(.MAX_HOLD(0)) u_arb0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .grant (grant0),
        .sel   (sel0),
        .busy  (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 5'b11111;
        tick();
        tick();
        n_vec++;
        if (grant4 !== 5'b0 || sel4 !== 3'd7 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold4: grant=%b sel=%0d busy=%b, want 00000/7/0", grant4, sel4, busy4);
        end
        n_vec++;
        if (grant0 !== 5'b0 || sel0 !== 3'd7 || busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold0: grant=%b sel=%0d busy=%b, want 00000/7/0", grant0, sel0, busy0);
        end
        req   = 5'b0;
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (grant4 !== 5'b0 || sel4 !== 3'd7 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_no_req: grant=%b sel=%0d busy=%b, want 00000/7/0", grant4, sel4, busy4);
        end
    endtask

    task automatic test_single();
        req = 5'b00100;
        tick();
        n_vec++;
        if (grant4 !== 5'b00100 || sel4 !== 3'd2 || busy4 !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: grant=%b sel=%0d busy=%b, want 00100/2/1", grant4, sel4, busy4);
        end
        for (int i = 2; i <= 4; i++) begin
            tick();
            n_vec++;
            if (sel4 !== 3'd2 || grant4 !== 5'b00100) begin
                n_err++;
                $display("FAIL single_hold edge%0d: grant=%b sel=%0d, want 00100/2", i, grant4, sel4);
            end
        end
        req = 5'b0;
        tick();
        n_vec++;
        if (grant4 !== 5'b0 || sel4 !== 3'd7 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: grant=%b sel=%0d busy=%b, want 00000/7/0", grant4, sel4, busy4);
        end
    endtask

    task automatic test_reset_mid();
        req = 5'b0;
        do_reset();
        req = 5'b00001;
        tick();
        n_vec++;
        if (sel4 !== 3'd0 || busy4 !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre_grant: sel=%0d busy=%b, want 0/1", sel4, busy4);
        end
        #2;
        rst_n = 1'b0;
        req   = 5'b00011;
        #1;
        n_vec++;
        if (grant4 !== 5'b0 || sel4 !== 3'd7 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async_clear: grant=%b sel=%0d busy=%b, want 00000/7/0", grant4, sel4, busy4);
        end
        #2;
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (grant4 !== 5'b00001 || sel4 !== 3'd0) begin
            n_err++;
            $display("FAIL mid_ptr_restart: grant=%b sel=%0d, want 00001/0", grant4, sel4);
        end
        req = 5'b0;
        tick();
    endtask

    task automatic test_rotation();
        logic [2:0] order [6];
        order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        req = 5'b0;
        do_reset();
        en  = 1'b1;
        req = 5'b11111;
        for (int o = 0; o < 6; o++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                n_vec++;
                if (sel4 !== order[o] || grant4 !== (5'b00001 << order[o]) || busy4 !== 1'b1) begin
                    n_err++;
                    $display("FAIL rotation slot%0d cyc%0d: grant=%b sel=%0d, want sel=%0d", o, c, grant4, sel4, order[o]);
                end
            end
        end
        n_vec++;
        if (sel0 !== 3'd0 || grant0 !== 5'b00001) begin
            n_err++;
            $display("FAIL rotation_unlimited_owner: grant=%b sel=%0d, want 00001/0", grant0, sel0);
        end
        req = 5'b0;
        tick();
    endtask

    task automatic test_wrap_handover();
        req = 5'b0;
        do_reset();
        req = 5'b10000;
        tick();
        n_vec++;
        if (sel4 !== 3'd4) begin
            n_err++;
            $display("FAIL wrap_owner4: sel=%0d, want 4", sel4);
        end
        req = 5'b11001;
        tick();
        req = 5'b01001;
        tick();
        n_vec++;
        if (sel4 !== 3'd0 || grant4 !== 5'b00001 || busy4 !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_to0: grant=%b sel=%0d, want 00001/0", grant4, sel4);
        end
        req = 5'b01000;
        tick();
        n_vec++;
        if (sel4 !== 3'd3 || grant4 !== 5'b01000 || busy4 !== 1'b1) begin
            n_err++;
            $display("FAIL handover_to3: grant=%b sel=%0d, want 01000/3", grant4, sel4);
        end
        req = 5'b0;
        tick();
        n_vec++;
        if (sel4 !== 3'd7 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_idle: sel=%0d busy=%b, want 7/0", sel4, busy4);
        end
    endtask

    task automatic test_enable();
        req = 5'b0;
        do_reset();
        en  = 1'b1;
        req = 5'b00010;
        tick();
        n_vec++;
        if (sel4 !== 3'd1) begin
            n_err++;
            $display("FAIL en_owner1: sel=%0d, want 1", sel4);
        end
        en  = 1'b0;
        req = 5'b01010;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++;
            if (sel4 !== 3'd1 || grant4 !== 5'b00010) begin
                n_err++;
                $display("FAIL en_no_preempt cyc%0d: grant=%b sel=%0d, want 00010/1", i, grant4, sel4);
            end
        end
        req = 5'b01000;
        tick();
        n_vec++;
        if (sel4 !== 3'd7 || grant4 !== 5'b0 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL en_release_idle: grant=%b sel=%0d busy=%b, want 00000/7/0", grant4, sel4, busy4);
        end
        tick();
        n_vec++;
        if (sel4 !== 3'd7) begin
            n_err++;
            $display("FAIL en_stay_idle: sel=%0d, want 7", sel4);
        end
        en = 1'b1;
        tick();
        n_vec++;
        if (sel4 !== 3'd3 || grant4 !== 5'b01000) begin
            n_err++;
            $display("FAIL en_regrant3: grant=%b sel=%0d, want 01000/3", grant4, sel4);
        end
        req = 5'b0;
        tick();
    endtask

    task automatic test_unlimited();
        req = 5'b0;
        do_reset();
        en  = 1'b1;
        req = 5'b00011;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_vec++;
            if (sel0 !== 3'd0 || grant0 !== 5'b00001) begin
                n_err++;
                $display("FAIL unlimited_hold cyc%0d: grant=%b sel=%0d, want 00001/0", i, grant0, sel0);
            end
        end
        req = 5'b00010;
        tick();
        n_vec++;
        if (sel0 !== 3'd1 || grant0 !== 5'b00010) begin
            n_err++;
            $display("FAIL unlimited_handover: grant=%b sel=%0d, want 00010/1", grant0, sel0);
        end
        req = 5'b0;
        tick();
        n_vec++;
        if (sel0 !== 3'd7 || busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL unlimited_idle: sel=%0d busy=%b, want 7/0", sel0, busy0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 5'b0;
        test_reset();
        test_single();
        test_reset_mid();
        test_rotation();
        test_wrap_handover();
        test_enable();
        test_unlimited();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
